// File: rtl/multi_score_engine.sv
// Multi-player hit scoring: per-player sync/debounce/saturating score, shared double-dabble sweep.
// Optional macro SCORE_COMBO_EN adds a per-player combo multiplier driven by a hit-to-hit timer.
module multi_score_engine #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCORE_W     = 14,
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned HIT_POINTS  = 10
`ifdef SCORE_COMBO_EN
  ,
  parameter int unsigned COMBO_WINDOW = 25_000_000
`endif
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            game_active,
  input  logic                            clear_scores,
  input  logic [NUM_PLAYERS-1:0]          ir_hit,
  input  logic [2*NUM_PLAYERS-1:0]        powerup_sel,
  output logic [NUM_PLAYERS*SCORE_W-1:0]  score_bin,
  output logic [NUM_PLAYERS*4*DIGITS-1:0] score_bcd,
  output logic                            bcd_valid,
  output logic [NUM_PLAYERS-1:0]          hit_pulse,
  output logic [2:0]                      leader
);

  localparam int unsigned MAX_SCORE = 10**DIGITS - 1;
  localparam int unsigned BCD_W     = 4 * DIGITS;
  localparam int unsigned DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PTR_W     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned IT_W      = $clog2(SCORE_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  function automatic int unsigned mult_of(input logic [1:0] code);
    case (code)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 3;
      default: return 5;
    endcase
  endfunction

  function automatic logic [SCORE_W-1:0] add_sat(input logic [SCORE_W-1:0] s,
                                                 input int unsigned pts);
    int unsigned sum;
    sum = 32'(s) + pts;
    if (sum > MAX_SCORE) return SCORE_W'(MAX_SCORE);
    return SCORE_W'(sum);
  endfunction

  function automatic logic [BCD_W+SCORE_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                                       input logic [SCORE_W-1:0] s);
    logic [BCD_W-1:0] adj;
    adj = b;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    return {adj, s} << 1;
  endfunction

  // ---------------- input path: 2-flop sync + debounce ----------------
  logic [NUM_PLAYERS-1:0] sync1_q, sync2_q, acc_q, acc_prev_q, hit_det;
  logic [DEB_W-1:0]       deb_cnt_q [NUM_PLAYERS];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      acc_prev_q <= '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= ir_hit;
      sync2_q    <= sync1_q;
      acc_prev_q <= acc_q;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (sync2_q[i] != acc_q[i]) begin
          if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
            acc_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign hit_det = acc_q & ~acc_prev_q;

  // ---------------- scoring ----------------
  logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] hit_pulse_q, hit_pulse_d;
  int unsigned            pts     [NUM_PLAYERS];

`ifdef SCORE_COMBO_EN
  localparam int unsigned CT_W = $clog2(COMBO_WINDOW + 1);
  logic [CT_W-1:0] ctimer_q  [NUM_PLAYERS];
  logic [CT_W-1:0] ctimer_d  [NUM_PLAYERS];
  logic [1:0]      combo_q   [NUM_PLAYERS];
  logic [1:0]      combo_d   [NUM_PLAYERS];
  logic [1:0]      combo_eff [NUM_PLAYERS];
`endif

  always_comb begin
    hit_pulse_d = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      score_d[i] = score_q[i];
      pts[i]     = HIT_POINTS * mult_of(powerup_sel[2*i +: 2]);
`ifdef SCORE_COMBO_EN
      // combo_eff is the count this hit would score with; timer expiry drops the streak
      combo_eff[i] = (ctimer_q[i] != '0) ?
                     ((combo_q[i] == 2'd3) ? 2'd3 : combo_q[i] + 2'd1) : 2'd0;
      ctimer_d[i]  = (ctimer_q[i] != '0) ? ctimer_q[i] - 1'b1 : '0;
      combo_d[i]   = (ctimer_q[i] > CT_W'(1)) ? combo_q[i] : 2'd0;
      pts[i]       = pts[i] * (32'(combo_eff[i]) + 32'd1);
`endif
      if (clear_scores) begin
        score_d[i] = '0;
`ifdef SCORE_COMBO_EN
        ctimer_d[i] = '0;
        combo_d[i]  = 2'd0;
`endif
      end else if (hit_det[i] && game_active) begin
        score_d[i]     = add_sat(score_q[i], pts[i]);
        hit_pulse_d[i] = 1'b1;
`ifdef SCORE_COMBO_EN
        ctimer_d[i] = CT_W'(COMBO_WINDOW);
        combo_d[i]  = combo_eff[i];
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= '0;
`ifdef SCORE_COMBO_EN
        ctimer_q[i] <= '0;
        combo_q[i]  <= 2'd0;
`endif
      end
    end else begin
      hit_pulse_q <= hit_pulse_d;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= score_d[i];
`ifdef SCORE_COMBO_EN
        ctimer_q[i] <= ctimer_d[i];
        combo_q[i]  <= combo_d[i];
`endif
      end
    end
  end

  // ---------------- time-shared BCD conversion ----------------
  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [IT_W-1:0]    it_q, it_d;
  logic [SCORE_W-1:0] bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [BCD_W-1:0]   bcd_q  [NUM_PLAYERS];
  logic [SCORE_W-1:0] snap_q [NUM_PLAYERS];
  logic               valid_q;
  logic [2:0]         leader_q, lead_d;
  logic [SCORE_W-1:0] best;
  logic               last_ptr;

  assign last_ptr = (ptr_q == PTR_W'(NUM_PLAYERS - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    it_d     = it_q;
    bin_sr_d = bin_sr_q;
    bcd_sr_d = bcd_sr_q;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        bin_sr_d = score_q[ptr_q];
        bcd_sr_d = '0;
        it_d     = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_sr_d, bin_sr_d} = dd_step(bcd_sr_q, bin_sr_q);
        it_d = it_q + 1'b1;
        if (it_q == IT_W'(SCORE_W - 1)) state_d = S_STORE;
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = last_ptr ? '0 : ptr_q + 1'b1;
      end
    endcase
    if (clear_scores) begin
      state_d = S_IDLE;
      ptr_d   = '0;
    end
  end

  // Leader comes only from per-sweep snapshots so it stays stable between sweeps
  always_comb begin
    lead_d = 3'd0;
    best   = snap_q[0];
    for (int unsigned k = 1; k < NUM_PLAYERS; k++) begin
      if (snap_q[k] > best) begin
        best   = snap_q[k];
        lead_d = 3'(k);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      it_q     <= '0;
      bin_sr_q <= '0;
      bcd_sr_q <= '0;
      valid_q  <= 1'b0;
      leader_q <= 3'd0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        bcd_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      it_q     <= it_d;
      bin_sr_q <= bin_sr_d;
      bcd_sr_q <= bcd_sr_d;
      if (clear_scores) begin
        valid_q <= 1'b0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) snap_q[i] <= '0;
      end else begin
        if (state_q == S_LOAD) snap_q[ptr_q] <= score_q[ptr_q];
        if (state_q == S_STORE) begin
          bcd_q[ptr_q] <= bcd_sr_q;
          if (last_ptr) begin
            valid_q  <= 1'b1;
            leader_q <= lead_d;
          end
        end
      end
    end
  end

  always_comb begin
    score_bin = '0;
    score_bcd = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      score_bin[i*SCORE_W +: SCORE_W] = score_q[i];
      score_bcd[i*BCD_W +: BCD_W]     = bcd_q[i];
    end
  end

  assign hit_pulse = hit_pulse_q;
  assign bcd_valid = valid_q;
  assign leader    = leader_q;

endmodule

// File: tb/tb_multi_score_engine.sv
// Randomized self-checking bench for multi_score_engine against a score/BCD/leader reference model.
module tb_multi_score_engine;
  localparam int NP  = 2;
  localparam int DG  = 4;
  localparam int SW  = 14;
  localparam int DEB = 8;
  localparam int HP  = 10;
  localparam int SWEEP = NP * (SW + 3);
  localparam int MAXS  = 9999;

  logic              clk = 1'b0;
  logic              rst;
  logic              game_active;
  logic              clear_scores;
  logic [NP-1:0]     ir_hit;
  logic [2*NP-1:0]   powerup_sel;
  logic [NP*SW-1:0]  score_bin;
  logic [NP*4*DG-1:0] score_bcd;
  logic              bcd_valid;
  logic [NP-1:0]     hit_pulse;
  logic [2:0]        leader;

  multi_score_engine #(
    .NUM_PLAYERS(NP),
    .DIGITS(DG),
    .SCORE_W(SW),
    .DEB_CYCLES(DEB),
    .HIT_POINTS(HP)
  ) dut (
    .clock(clk),
    .reset(rst),
    .game_active(game_active),
    .clear_scores(clear_scores),
    .ir_hit(ir_hit),
    .powerup_sel(powerup_sel),
    .score_bin(score_bin),
    .score_bcd(score_bcd),
    .bcd_valid(bcd_valid),
    .hit_pulse(hit_pulse),
    .leader(leader)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int clear_cyc = 0;
  int model_score [NP];
  int exp_pulses  [NP];
  int pulse_cnt   [NP];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) if (hit_pulse[p]) pulse_cnt[p]++;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int mult_of(input int code);
    int m[4] = '{1, 2, 3, 5};
    return m[code];
  endfunction

  function automatic int unsigned to_bcd(input int v);
    int unsigned r = 0;
    int x = v;
    for (int d = 0; d < DG; d++) begin
      r = r | (32'(x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int model_leader();
    int best = 0;
    for (int p = 1; p < NP; p++) if (model_score[p] > model_score[best]) best = p;
    return best;
  endfunction

  task automatic do_hit(input int p, input int code, input bit active);
    game_active = active;
    powerup_sel[2*p +: 2] = 2'(code);
    ir_hit[p] = 1'b1;
    tick(DEB + 4);
    ir_hit[p] = 1'b0;
    tick(DEB + 4);
    if (active) begin
      model_score[p] += HP * mult_of(code);
      if (model_score[p] > MAXS) model_score[p] = MAXS;
      exp_pulses[p]++;
    end
    check_eq($sformatf("score_p%0d", p), score_bin[p*SW +: SW], model_score[p]);
    check_eq($sformatf("pulses_p%0d", p), pulse_cnt[p], exp_pulses[p]);
  endtask

  task automatic check_display(input string tag);
    tick(2 * SWEEP + 2);
    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("%s_bin_p%0d", tag, p), score_bin[p*SW +: SW], model_score[p]);
      check_eq($sformatf("%s_bcd_p%0d", tag, p), score_bcd[p*16 +: 16], to_bcd(model_score[p]));
    end
    check_eq({tag, "_leader"}, leader, model_leader());
    check_eq({tag, "_valid"}, bcd_valid, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_bin"}, score_bin, 0);
    check_eq({tag, "_bcd"}, score_bcd, 0);
    check_eq({tag, "_valid"}, bcd_valid, 0);
    check_eq({tag, "_pulse"}, hit_pulse, 0);
    check_eq({tag, "_leader"}, leader, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int guard;
    bit found;
    rst = 1'b1; game_active = 1'b0; clear_scores = 1'b0; ir_hit = '0; powerup_sel = '0;
    for (int p = 0; p < NP; p++) begin
      model_score[p] = 0; exp_pulses[p] = 0; pulse_cnt[p] = 0;
    end
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // first hit on player 0, with latency measurement
    game_active = 1'b1;
    ir_hit[0] = 1'b1;
    lat = 0; found = 1'b0;
    for (int n = 1; n <= DEB + 10; n++) begin
      tick(1);
      if (!found && hit_pulse[0]) begin found = 1'b1; lat = n; end
    end
    ir_hit[0] = 1'b0;
    tick(DEB + 4);
    model_score[0] = 10; exp_pulses[0] = 1;
    check_eq("latency", lat, DEB + 3);
    check_eq("pulses_p0_first", pulse_cnt[0], 1);
    check_display("first");

    // glitch shorter than the debounce window
    ir_hit[1] = 1'b1;
    tick(DEB - 5);
    ir_hit[1] = 1'b0;
    tick(DEB + 10);
    check_eq("glitch_pulses", pulse_cnt[1], 0);
    check_eq("glitch_score", score_bin[SW +: SW], 0);

    for (int k = 0; k < 3; k++) do_hit(1, 3, 1'b1);
    check_display("x5");

    for (int k = 0; k < 14; k++)
      do_hit($urandom_range(0, NP - 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
    check_display("rand");

    // drive player 0 into saturation, then one more hit must pulse but hold
    guard = 0;
    while (model_score[0] < MAXS && guard < 1200) begin
      do_hit(0, $urandom_range(0, 3), 1'b1);
      guard++;
    end
    check_eq("sat_reached", model_score[0] == MAXS, 1);
    do_hit(0, 0, 1'b1);
    check_display("sat");

    // hit coinciding with clear: clear wins
    game_active = 1'b1;
    powerup_sel = '0;
    ir_hit[0] = 1'b1;
    tick(DEB + 2);
    clear_scores = 1'b1;
    tick(1);
    clear_scores = 1'b0;
    clear_cyc = cyc;
    for (int p = 0; p < NP; p++) model_score[p] = 0;
    check_eq("clr_pulse", hit_pulse, 0);
    check_eq("clr_bin", score_bin, 0);
    check_eq("clr_valid", bcd_valid, 0);
    tick(SWEEP - 1);
    check_eq("clr_valid_early", bcd_valid, 0);
    tick(1);
    check_eq("clr_valid_rise", bcd_valid, 1);
    ir_hit[0] = 1'b0;
    tick(DEB + 4);
    check_eq("clr_pulses_p0", pulse_cnt[0], exp_pulses[0]);

    // tie: lowest index leads
    do_hit(0, 1, 1'b1);
    do_hit(0, 1, 1'b1);
    do_hit(1, 1, 1'b1);
    do_hit(1, 1, 1'b1);
    check_display("tie");

    // reset landing in the SHIFT phase of the sweep
    guard = 0;
    while (((cyc - clear_cyc) % (SW + 3)) != 8 && guard < 40) begin
      tick(1);
      guard++;
    end
    check_eq("shift_phase_found", guard < 40, 1);
    rst = 1'b1;
    tick(1);
    check_all_zero("mid_shift_reset");
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
